// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order buffer from rename to the RS banks, snooping writeback while entries wait.
// Define DISPATCH_QUEUE_BYPASS_EN for a same-cycle input-to-output path when the queue is empty.
module dispatch_queue #(
   parameter int DEPTH     = 8,
   parameter int IN_WIDTH  = 2,
   parameter int OUT_WIDTH = 2,
   parameter int DATA_W    = 64,
   parameter int PREG_W    = 6,
   parameter int WB_WIDTH  = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush_i,
   input  logic [IN_WIDTH-1:0]           in_valid_i,
   output logic                          in_ready_o,
   input  logic [IN_WIDTH*DATA_W-1:0]    in_data_i,
   input  logic [IN_WIDTH*PREG_W-1:0]    in_psrc0_i,
   input  logic [IN_WIDTH*PREG_W-1:0]    in_psrc1_i,
   input  logic [IN_WIDTH-1:0]           in_psrc0_valid_i,
   input  logic [IN_WIDTH-1:0]           in_psrc1_valid_i,
   input  logic [IN_WIDTH-1:0]           in_psrc0_ready_i,
   input  logic [IN_WIDTH-1:0]           in_psrc1_ready_i,
   input  logic [WB_WIDTH-1:0]           wb_i,
   input  logic [WB_WIDTH*PREG_W-1:0]    wb_pdest_i,
   output logic [OUT_WIDTH-1:0]          out_valid_o,
   input  logic [OUT_WIDTH-1:0]          out_ready_i,
   output logic [OUT_WIDTH*DATA_W-1:0]   out_data_o,
   output logic [OUT_WIDTH*PREG_W-1:0]   out_psrc0_o,
   output logic [OUT_WIDTH*PREG_W-1:0]   out_psrc1_o,
   output logic [OUT_WIDTH-1:0]          out_psrc0_valid_o,
   output logic [OUT_WIDTH-1:0]          out_psrc1_valid_o,
   output logic [OUT_WIDTH-1:0]          out_psrc0_ready_o,
   output logic [OUT_WIDTH-1:0]          out_psrc1_ready_o,
   output logic [$clog2(DEPTH):0]        count_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]                head, tail, oidx;
   logic [CW-1:0]                count, enq, deq, nin;
   logic [DATA_W-1:0]            data_q [DEPTH];
   logic [PREG_W-1:0]            t0_q [DEPTH];
   logic [PREG_W-1:0]            t1_q [DEPTH];
   logic [DEPTH-1:0]             v0_q, v1_q, r0_q, r1_q;
   logic [IN_WIDTH-1:0]          wr_en, in_r0, in_r1;
   logic [IN_WIDTH-1:0][PW-1:0]  wr_idx;
   logic                         pre;

   function automatic logic hit(input logic [PREG_W-1:0] tag, input logic [WB_WIDTH-1:0] wb,
                                input logic [WB_WIDTH*PREG_W-1:0] pd);
      hit = 1'b0;
      for (int w = 0; w < WB_WIDTH; w++) hit = hit | (wb[w] && (pd[w*PREG_W +: PREG_W] == tag));
   endfunction

   assign count_o = count;

   always_comb begin
      in_ready_o = !flush_i && (CW'(DEPTH) - count >= CW'(IN_WIDTH));
      out_valid_o = '0;
      out_data_o = '0;
      out_psrc0_o = '0;
      out_psrc1_o = '0;
      out_psrc0_valid_o = '0;
      out_psrc1_valid_o = '0;
      out_psrc0_ready_o = '0;
      out_psrc1_ready_o = '0;
      oidx = '0;
      deq = '0;
      nin = '0;
      pre = 1'b1;
      // lane k is offered only once every older lane is being accepted
      for (int k = 0; k < OUT_WIDTH; k++) begin
         oidx = head + PW'(k);
         out_data_o[k*DATA_W +: DATA_W] = data_q[oidx];
         out_psrc0_o[k*PREG_W +: PREG_W] = t0_q[oidx];
         out_psrc1_o[k*PREG_W +: PREG_W] = t1_q[oidx];
         out_psrc0_valid_o[k] = v0_q[oidx];
         out_psrc1_valid_o[k] = v1_q[oidx];
         out_psrc0_ready_o[k] = r0_q[oidx] | (v0_q[oidx] & hit(t0_q[oidx], wb_i, wb_pdest_i));
         out_psrc1_ready_o[k] = r1_q[oidx] | (v1_q[oidx] & hit(t1_q[oidx], wb_i, wb_pdest_i));
         out_valid_o[k] = !flush_i && (count > CW'(k)) && pre;
         deq = deq + CW'(out_valid_o[k] & out_ready_i[k]);
         pre = pre & out_ready_i[k];
      end
      for (int i = 0; i < IN_WIDTH; i++) begin
         nin = nin + CW'(in_valid_i[i]);
         wr_en[i] = in_ready_o & in_valid_i[i];
         wr_idx[i] = tail + PW'(i);
         in_r0[i] = in_psrc0_ready_i[i] |
                    (in_psrc0_valid_i[i] & hit(in_psrc0_i[i*PREG_W +: PREG_W], wb_i, wb_pdest_i));
         in_r1[i] = in_psrc1_ready_i[i] |
                    (in_psrc1_valid_i[i] & hit(in_psrc1_i[i*PREG_W +: PREG_W], wb_i, wb_pdest_i));
      end
      enq = in_ready_o ? nin : '0;
`ifdef DISPATCH_QUEUE_BYPASS_EN
      // empty queue: inputs go straight to the banks; rejected lanes fall back into the queue
      if (count == '0 && !flush_i) begin
         logic [CW-1:0] byp;
         byp = '0;
         pre = 1'b1;
         for (int k = 0; k < ((IN_WIDTH < OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH); k++) begin
            out_data_o[k*DATA_W +: DATA_W] = in_data_i[k*DATA_W +: DATA_W];
            out_psrc0_o[k*PREG_W +: PREG_W] = in_psrc0_i[k*PREG_W +: PREG_W];
            out_psrc1_o[k*PREG_W +: PREG_W] = in_psrc1_i[k*PREG_W +: PREG_W];
            out_psrc0_valid_o[k] = in_psrc0_valid_i[k];
            out_psrc1_valid_o[k] = in_psrc1_valid_i[k];
            out_psrc0_ready_o[k] = in_r0[k];
            out_psrc1_ready_o[k] = in_r1[k];
            out_valid_o[k] = in_ready_o && in_valid_i[k] && pre;
            byp = byp + CW'(out_valid_o[k] & out_ready_i[k]);
            pre = pre & out_ready_i[k];
         end
         for (int i = 0; i < IN_WIDTH; i++) begin
            wr_en[i] = in_ready_o && in_valid_i[i] && (CW'(i) >= byp);
            wr_idx[i] = tail + PW'(i) - PW'(byp);
         end
         enq = in_ready_o ? nin - byp : '0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head <= '0;
         tail <= '0;
         count <= '0;
         v0_q <= '0;
         v1_q <= '0;
         r0_q <= '0;
         r1_q <= '0;
      end else if (flush_i) begin
         head <= '0;
         tail <= '0;
         count <= '0;
         v0_q <= '0;
         v1_q <= '0;
         r0_q <= '0;
         r1_q <= '0;
      end else begin
         for (int e = 0; e < DEPTH; e++) begin
            r0_q[e] <= r0_q[e] | (v0_q[e] & hit(t0_q[e], wb_i, wb_pdest_i));
            r1_q[e] <= r1_q[e] | (v1_q[e] & hit(t1_q[e], wb_i, wb_pdest_i));
         end
         for (int i = 0; i < IN_WIDTH; i++) begin
            if (wr_en[i]) begin
               v0_q[wr_idx[i]] <= in_psrc0_valid_i[i];
               v1_q[wr_idx[i]] <= in_psrc1_valid_i[i];
               r0_q[wr_idx[i]] <= in_r0[i];
               r1_q[wr_idx[i]] <= in_r1[i];
            end
         end
         head <= head + PW'(deq);
         tail <= tail + PW'(enq);
         count <= count + enq - deq;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < IN_WIDTH; i++) begin
         if (wr_en[i]) begin
            data_q[wr_idx[i]] <= in_data_i[i*DATA_W +: DATA_W];
            t0_q[wr_idx[i]] <= in_psrc0_i[i*PREG_W +: PREG_W];
            t1_q[wr_idx[i]] <= in_psrc1_i[i*PREG_W +: PREG_W];
         end
      end
   end

   assert property (@(posedge clk) disable iff (!rst_n)
      (in_valid_i & (in_valid_i + IN_WIDTH'(1))) == '0);
endmodule
